// File: rtl/jt900h_simram_pkg.sv
// Shared types and constants for the JT900H simulation RAM and its register dump.
package jt900h_sim_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DUMP = 2'd1,
        DONE = 2'd2
    } dump_state_t;

    localparam int DUMP_LEN_DEFAULT = 84;

    // Byte offsets of the CPU register groups inside the dump buffer
    localparam int REG_BANK_OFS = 0;   // bank registers occupy bytes 0-63
    localparam int REG_BANK_LEN = 64;
    localparam int REG_IDX_OFS  = 64;  // index registers
    localparam int REG_SR_OFS   = 80;  // status register

endpackage

// File: rtl/jt900h_simram_if.sv
// CPU-side RAM bus: byte address, write data/enables, read data and ready.
interface jt900h_simram_if #(
    parameter int DW = 16
);
    import jt900h_sim_pkg::*;

    logic [23:0]     ram_addr;
    logic [DW-1:0]   ram_din;
    logic [DW/8-1:0] ram_we;
    logic [DW-1:0]   ram_dout;
    logic            ram_rdy;

    modport master (
        output ram_addr, ram_din, ram_we,
        input  ram_dout, ram_rdy
    );

    modport slave (
        input  ram_addr, ram_din, ram_we,
        output ram_dout, ram_rdy
    );

endinterface

// File: rtl/jt900h_simram_dump.sv
// Register-dump sequencer: walks dmp_addr over the CPU register file,
// captures each byte into a 256-byte buffer and stalls the CPU clock enable.
module jt900h_simram_dump
    import jt900h_sim_pkg::*;
#(
    parameter int CENDIV   = 1,
    parameter int DUMP_LEN = DUMP_LEN_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        trig,
    output logic        cen,
    output logic [7:0]  dmp_addr,
    input  logic [7:0]  dmp_din,
    output logic        dump_done,
    input  logic [7:0]  buf_addr,
    output logic [31:0] buf_dout
);

    localparam logic [7:0] LAST = 8'(DUMP_LEN);

    dump_state_t state, state_nx;
    logic [7:0]  dbuf [256];
    logic [7:0]  a1, a2, a3;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state logic; triggers are only honoured from IDLE
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (trig) state_nx = DUMP;
            DUMP:    if (dmp_addr == LAST) state_nx = DONE;
            DONE:    state_nx = DONE;
            default: state_nx = IDLE;
        endcase
    end

    // Dump address counter, held once the last byte is reached
    always_ff @(posedge clk) begin
        if (rst)                                dmp_addr <= '0;
        else if (state == DUMP && dmp_addr != LAST) dmp_addr <= dmp_addr + 8'd1;
    end

    // Capture lags the address by one cycle to match the CPU read latency
    always_ff @(posedge clk) begin
        if (state == DUMP && dmp_addr != 8'd0) dbuf[dmp_addr - 8'd1] <= dmp_din;
    end

    assign dump_done = (state == DONE);

    generate
        if (CENDIV == 2) begin : g_cendiv2
            logic cen_r;
            // Half-rate enable while the CPU is running
            always_ff @(posedge clk) begin
                if (rst) cen_r <= 1'b1;
                else     cen_r <= ~cen_r;
            end
            assign cen = (state == IDLE) && cen_r;
        end else begin : g_cendiv1
            assign cen = (state == IDLE);
        end
    endgenerate

    assign a1 = buf_addr + 8'd1;
    assign a2 = buf_addr + 8'd2;
    assign a3 = buf_addr + 8'd3;
    assign buf_dout = {dbuf[a3], dbuf[a2], dbuf[a1], dbuf[buf_addr]};

endmodule

// File: rtl/jt900h_simram.sv
// Simulation RAM for the JT900H CPU with optional wait states and a
// register-dump capture that starts when the CPU leaves RAM space.
module jt900h_simram
    import jt900h_sim_pkg::*;
#(
    parameter int          DW       = 16,
    parameter int          MW       = 9,
    parameter int          WAIT     = 0,
    parameter int          CENDIV   = 1,
    parameter logic [23:0] END_RAM  = 24'h400,
    parameter int          DUMP_LEN = DUMP_LEN_DEFAULT,
    parameter              HEXFILE  = "test.hex"
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  cen,
    jt900h_simram_if.slave        bus,
    output logic [7:0]            dmp_addr,
    input  logic [7:0]            dmp_din,
    input  logic                  dump_req,
    output logic                  dump_done,
    input  logic [7:0]            buf_addr,
    output logic [31:0]           buf_dout
);

    localparam int BL = $clog2(DW/8);

    logic [DW-1:0] mem [2**MW];
    logic [MW-1:0] idx;
    logic          trig;

    assign idx          = bus.ram_addr[MW+BL-1:BL];
    assign bus.ram_dout = mem[idx];

    generate
        if (WAIT == 0) begin : g_nowait
            assign bus.ram_rdy = 1'b1;
        end else begin : g_wait
            logic [MW-1:0] prev_idx;
            logic [2:0]    cnt, cnt_eff;
            // Reload is applied within the address-change cycle itself, so a
            // write presented together with a new address is already blocked.
            assign cnt_eff     = (idx != prev_idx) ? 3'(WAIT) : cnt;
            assign bus.ram_rdy = (cnt_eff == 3'd0);
            // Wait-state counter tracking the previous word index
            always_ff @(posedge clk) begin
                prev_idx <= idx;
                if (rst)                   cnt <= 3'(WAIT);
                else if (cnt_eff == 3'd0)  cnt <= 3'd0;
                else                       cnt <= cnt_eff - 3'd1;
            end
        end
    endgenerate

    // Byte-masked write, only once the access is ready
    always_ff @(posedge clk) begin
        if (bus.ram_rdy) begin
            for (int unsigned b = 0; b < DW/8; b++) begin
                if (bus.ram_we[b]) mem[idx][8*b +: 8] <= bus.ram_din[8*b +: 8];
            end
        end
    end

`ifdef SIMULATION
    // Trace CPU writes
    always_ff @(posedge clk) begin
        if (bus.ram_rdy && (|bus.ram_we))
            $display("RAM: %h written to %h", bus.ram_din, {bus.ram_addr[23:BL], BL'(0)});
    end
`endif

    assign trig = (bus.ram_addr >= END_RAM) || dump_req;

    jt900h_simram_dump #(
        .CENDIV   (CENDIV),
        .DUMP_LEN (DUMP_LEN)
    ) u_dump (
        .clk       (clk),
        .rst       (rst),
        .trig      (trig),
        .cen       (cen),
        .dmp_addr  (dmp_addr),
        .dmp_din   (dmp_din),
        .dump_done (dump_done),
        .buf_addr  (buf_addr),
        .buf_dout  (buf_dout)
    );

endmodule
